// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core request/response and word-bus signals of the memory access unit
//   req_*  : core load/store request (valid/ready), resp_* : one-cycle completion
//   bus_*  : word-addressed memory bus with req/ack handshake
//   slave  : view taken by mem_access_unit, master : view taken by core + memory
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [2:0]  req_mask;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        bus_req;
   logic        bus_wr;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   modport slave (
      input  req_valid, req_wr, req_mask, req_addr, req_wdata, bus_ack, bus_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             bus_req, bus_wr, bus_addr, bus_wdata, bus_be
   );
   modport master (
      output req_valid, req_wr, req_mask, req_addr, req_wdata, bus_ack, bus_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             bus_req, bus_wr, bus_addr, bus_wdata, bus_be
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage driving a word bus with lane steering, load extension and timeout
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   mau    : request/response and memory bus signals (slave view)
//   req_mask encoding: 0 mt_x, 1 mt_b, 2 mt_h, 3 mt_w, 4 mt_bu, 5 mt_hu, 6..7 unknown
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input logic              clk_i,
   input logic              rst_ni,
   mem_access_unit_if.slave mau
);
   localparam logic [2:0] MT_X  = 3'd0;
   localparam logic [2:0] MT_B  = 3'd1;
   localparam logic [2:0] MT_H  = 3'd2;
   localparam logic [2:0] MT_W  = 3'd3;
   localparam logic [2:0] MT_BU = 3'd4;
   localparam logic [2:0] MT_HU = 3'd5;
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
   state_e             state_q, state_d;
   logic               wr_q, wr_d;
   logic [2:0]         mask_q, mask_d;
   logic [1:0]         off_q, off_d;
   logic               bus_req_q, bus_req_d;
   logic               bus_wr_q, bus_wr_d;
   logic [31:0]        bus_addr_q, bus_addr_d;
   logic [31:0]        bus_wdata_q, bus_wdata_d;
   logic [3:0]         bus_be_q, bus_be_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               is_byte, is_half, acc_err, timeout;
   logic [31:0]        st_data, sh, ld_data;
   logic [3:0]         st_be;
   always_comb begin
      is_byte = mau.req_mask inside {MT_B, MT_BU};
      is_half = mau.req_mask inside {MT_H, MT_HU};
      // unknown encodings fall out as "neither byte, half nor word"
      acc_err = mau.req_mask == MT_X || !(is_byte || is_half || mau.req_mask == MT_W) ||
                (is_half && mau.req_addr[0]) ||
                (mau.req_mask == MT_W && mau.req_addr[1:0] != 2'b00) ||
                (mau.req_wr && mau.req_mask inside {MT_BU, MT_HU});
      st_data = is_byte ? {4{mau.req_wdata[7:0]}} : is_half ? {2{mau.req_wdata[15:0]}} : mau.req_wdata;
      st_be   = !mau.req_wr ? 4'b1111 : is_byte ? 4'b0001 << mau.req_addr[1:0] :
                is_half ? (mau.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      sh      = mau.bus_rdata >> {off_q, 3'b000};
      ld_data = mask_q == MT_B  ? {{24{sh[7]}}, sh[7:0]} :
                mask_q == MT_BU ? {24'd0, sh[7:0]} :
                mask_q == MT_H  ? {{16{sh[15]}}, sh[15:0]} :
                mask_q == MT_HU ? {16'd0, sh[15:0]} : mau.bus_rdata;
      timeout = TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         mask_q      <= MT_X;
         off_q       <= 2'b00;
         bus_req_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         mask_q      <= mask_d;
         off_q       <= off_d;
         bus_req_q   <= bus_req_d;
         bus_wr_q    <= bus_wr_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      mask_d      = mask_q;
      off_d       = off_q;
      bus_req_d   = bus_req_q;
      bus_wr_d    = bus_wr_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         IDLE: if (mau.req_valid) begin
            wr_d   = mau.req_wr;
            mask_d = mau.req_mask;
            off_d  = mau.req_addr[1:0];
            if (acc_err) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               state_d     = BUS;
               bus_req_d   = 1'b1;
               bus_wr_d    = mau.req_wr;
               bus_addr_d  = {mau.req_addr[31:2], 2'b00};
               bus_wdata_d = st_data;
               bus_be_d    = st_be;
            end
         end
         BUS: if (mau.bus_ack) begin
            // ack takes priority over a timeout expiring in the same cycle
            state_d   = RESP;
            bus_req_d = 1'b0;
            rdata_d   = wr_q ? '0 : ld_data;
            err_d     = 1'b0;
         end else if (timeout) begin
            state_d   = RESP;
            bus_req_d = 1'b0;
            rdata_d   = '0;
            err_d     = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      mau.req_ready  = state_q == IDLE;
      mau.resp_valid = state_q == RESP;
      mau.resp_rdata = rdata_q;
      mau.resp_err   = err_q;
      mau.bus_req    = bus_req_q;
      mau.bus_wr     = bus_wr_q;
      mau.bus_addr   = bus_addr_q;
      mau.bus_wdata  = bus_wdata_q;
      mau.bus_be     = bus_be_q;
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
   localparam int TO = 4;
   localparam logic [2:0] MT_X = 3'd0, MT_B = 3'd1, MT_H = 3'd2, MT_W = 3'd3, MT_BU = 3'd4, MT_HU = 3'd5;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   mem_access_unit_if mau();
   mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .mau(mau));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int size_of(input logic [2:0] mask);
      return mask inside {MT_B, MT_BU} ? 1 : mask inside {MT_H, MT_HU} ? 2 : 4;
   endfunction
   function automatic logic model_err(input logic wr, input logic [2:0] mask, input logic [31:0] addr);
      case (mask)
         MT_B:    return 1'b0;
         MT_BU:   return wr;
         MT_H:    return addr % 2 != 0;
         MT_HU:   return wr || addr % 2 != 0;
         MT_W:    return addr % 4 != 0;
         default: return 1'b1;
      endcase
   endfunction
   function automatic logic [31:0] model_load(input logic [2:0] mask, input logic [31:0] addr, input logic [31:0] rdata);
      longint v;
      int     sz;
      sz = size_of(mask);
      if (sz == 4) return rdata;
      v = (longint'(rdata) >> (8 * (addr % 4))) % (longint'(1) << (8 * sz));
      if ((mask == MT_B || mask == MT_H) && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      return v[31:0];
   endfunction
   // delay = number of bus_req-high cycles before ack; beyond TO means the bus never answers in time
   task automatic access(input logic wr, input logic [2:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
      logic        perr, exp_err;
      int          sz, exp_hi, hi, cyc;
      logic [31:0] exp_rd, exp_be, exp_wd;
      perr    = model_err(wr, mask, addr);
      sz      = size_of(mask);
      exp_hi  = perr ? 0 : (delay <= TO ? delay : TO);
      exp_err = perr || delay > TO;
      exp_rd  = (exp_err || wr) ? 32'd0 : model_load(mask, addr, rdata);
      exp_be  = wr ? ((32'd1 << sz) - 1) << (addr % 4) : 32'hF;
      exp_wd  = sz == 1 ? (wdata & 32'hFF) * 32'h01010101 : sz == 2 ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
      @(negedge clk);
      chk("req_ready_idle", 32'(mau.req_ready), 1);
      mau.req_valid = 1'b1;
      mau.req_wr    = wr;
      mau.req_mask  = mask;
      mau.req_addr  = addr;
      mau.req_wdata = wdata;
      @(negedge clk);
      mau.req_valid = 1'b0;
      mau.req_addr  = $urandom;
      mau.req_wdata = $urandom;
      hi  = 0;
      cyc = 0;
      while (!mau.resp_valid && cyc < 20) begin
         chk("bus_req", 32'(mau.bus_req), 32'(cyc < exp_hi));
         chk("req_ready_busy", 32'(mau.req_ready), 0);
         if (mau.bus_req) begin
            chk("bus_wr", 32'(mau.bus_wr), 32'(wr));
            chk("bus_addr", mau.bus_addr, addr & 32'hFFFF_FFFC);
            chk("bus_be", 32'(mau.bus_be), exp_be);
            if (wr) chk("bus_wdata", mau.bus_wdata, exp_wd);
            hi++;
         end
         mau.bus_ack   = mau.bus_req && hi == delay;
         mau.bus_rdata = mau.bus_ack ? rdata : $urandom;
         @(negedge clk);
         mau.bus_ack = 1'b0;
         cyc++;
      end
      chk("latency", 32'(cyc), 32'(exp_hi));
      chk("resp_valid", 32'(mau.resp_valid), 1);
      chk("resp_err", 32'(mau.resp_err), 32'(exp_err));
      chk("resp_rdata", mau.resp_rdata, exp_rd);
      chk("bus_req_done", 32'(mau.bus_req), 0);
      @(negedge clk);
      chk("resp_pulse", 32'(mau.resp_valid), 0);
      chk("resp_rdata_hold", mau.resp_rdata, exp_rd);
      chk("resp_err_hold", 32'(mau.resp_err), 32'(exp_err));
   endtask
   initial begin
      mau.req_valid = 1'b0;
      mau.req_wr    = 1'b0;
      mau.req_mask  = MT_X;
      mau.req_addr  = '0;
      mau.req_wdata = '0;
      mau.bus_ack   = 1'b0;
      mau.bus_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(mau.req_ready), 1);
      chk("rst_resp_valid", 32'(mau.resp_valid), 0);
      chk("rst_resp_err", 32'(mau.resp_err), 0);
      chk("rst_resp_rdata", mau.resp_rdata, 0);
      chk("rst_bus_req", 32'(mau.bus_req), 0);
      chk("rst_bus_wr", 32'(mau.bus_wr), 0);
      chk("rst_bus_addr", mau.bus_addr, 0);
      chk("rst_bus_wdata", mau.bus_wdata, 0);
      chk("rst_bus_be", 32'(mau.bus_be), 0);
      rst_n = 1'b1;
      access(1'b0, MT_B,  32'h1003, 32'h0,        32'h80FF_1234, 1);
      access(1'b0, MT_HU, 32'h2002, 32'h0,        32'hBEEF_0000, 4);
      access(1'b1, MT_H,  32'h3002, 32'h0000_A5A5, 32'h0,        2);
      access(1'b0, MT_W,  32'h4001, 32'h0,        32'h1111_2222, 1);
      access(1'b0, MT_X,  32'h4000, 32'h0,        32'h1111_2222, 1);
      access(1'b1, MT_BU, 32'h4000, 32'h55,       32'h0,         1);
      access(1'b0, MT_W,  32'h5000, 32'h0,        32'hDEAD_BEEF, 99);
      access(1'b0, MT_W,  32'h5004, 32'h0,        32'hCAFE_F00D, 4);
      access(1'b1, MT_B,  32'h6001, 32'h1234_5677, 32'h0,        3);
      // reset two cycles into a bus wait
      @(negedge clk);
      mau.req_valid = 1'b1;
      mau.req_wr    = 1'b0;
      mau.req_mask  = MT_W;
      mau.req_addr  = 32'h7000;
      @(negedge clk);
      mau.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_bus_req", 32'(mau.bus_req), 1);
      rst_n = 1'b0;
      #1;
      chk("async_bus_req", 32'(mau.bus_req), 0);
      chk("async_resp_valid", 32'(mau.resp_valid), 0);
      chk("async_req_ready", 32'(mau.req_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_resp_valid", 32'(mau.resp_valid), 0);
      chk("post_rst_req_ready", 32'(mau.req_ready), 1);
      chk("post_rst_bus_req", 32'(mau.bus_req), 0);
      access(1'b0, MT_H, 32'h7002, 32'h0, 32'h8001_7FFF, 2);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
         access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(1, 6));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the ISS decode/execute functions.
- Accepts one load/store per transaction from the core, using the ALU-computed address and the `ME_MaskType` produced by `get_memory_mask`.
- Drives a word-addressed memory bus with a req/ack handshake, steering byte lanes for stores and aligning plus sign/zero-extending data for loads.
- Flags misaligned, unknown-mask and timed-out accesses back to the core.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent waiting for `bus_ack` before aborting. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept an access; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_mask  in  ME_MaskType  access size and signedness: mt_b, mt_h, mt_w, mt_bu, mt_hu, mt_x.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended to 32 bits. 0 for stores and for errors.
- resp_err  out  1  valid with `resp_valid`; 1 = misaligned, mt_x, or timeout.
- bus_req  out  1  bus request, held until ack or timeout.
- bus_wr  out  1  bus write enable.
- bus_addr  out  32  `{req_addr[31:2], 2'b00}`.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables. All 1s for loads.
- bus_ack  in  1  memory completes the access in this cycle.
- bus_rdata  in  32  read word, valid when `bus_ack`=1.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - bus_req=0, bus_wr=0, bus_addr=0, bus_wdata=0, bus_be=0.
  - Timeout counter=0.
  - Reset mid-transaction drops `bus_req` immediately and produces no response.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Accept when req_valid && req_ready. Latch wr, mask, addr and wdata.
  - Error check: mt_h/mt_hu with addr[0]≠0, mt_w with addr[1:0]≠0, mt_x, or store with mt_bu/mt_hu.
  - On error: go to RESP with err=1. No bus cycle is issued.
  - Otherwise: go to BUS. bus_req=1 starts in the cycle after acceptance.
- BUS:
  - bus_* outputs are registered and stay stable while bus_req=1.
  - On bus_ack: capture bus_rdata, deassert bus_req next cycle, go to RESP with err=0.
  - Counter increments each BUS cycle without ack. When counter == TIMEOUT_CYCLES-1 and there is no ack: go to RESP with err=1 and deassert bus_req.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP:
  - resp_valid=1 for exactly one cycle. There is no back-pressure.
  - Next state is IDLE; counter clears.
  - req_ready=0 in BUS and RESP.
- Latency:
  - Accept at cycle t. bus_req is high from t+1.
  - Ack at cycle t+k. resp_valid at t+k+1.
  - Best case (k=1) is 2 cycles from accept to response.
  - Error response arrives at t+1.
- Store lane steering:
  - b: bus_wdata={4{wdata[7:0]}}, bus_be=4'b0001<<addr[1:0].
  - h: bus_wdata={2{wdata[15:0]}}, bus_be = addr[1] ? 4'b1100 : 4'b0011.
  - w: bus_wdata=wdata, bus_be=4'b1111.
- Load extraction:
  - sh = bus_rdata >> (8*addr[1:0]).
  - mt_b: sign-extend sh[7:0].
  - mt_bu: zero-extend sh[7:0].
  - mt_h: sign-extend sh[15:0].
  - mt_hu: zero-extend sh[15:0].
  - mt_w: bus_rdata.
- Output hold:
  - resp_rdata and resp_err hold their last values when resp_valid=0.
  - bus_wr, bus_addr and bus_wdata may hold when bus_req=0.
- req_valid is ignored outside IDLE.
- TIMEOUT_CYCLES=0: wait for ack indefinitely.

Test Plan:
- Load byte, signed: addr=0x1003, mt_b, bus_rdata=0x80FF_1234, ack 1 cycle after bus_req → bus_addr=0x1000, bus_be=4'b1111, resp_rdata=0xFFFF_FF80, err=0, resp 2 cycles after accept.
- Load halfword, unsigned: addr=0x2002, mt_hu, rdata=0xBEEF_0000, ack after 3 wait cycles → resp_rdata=0x0000_BEEF, resp_valid exactly one cycle.
- Store halfword: addr=0x3002, mt_h, wdata=0x0000_A5A5 → bus_wr=1, bus_be=4'b1100, bus_wdata=0xA5A5_A5A5, resp_rdata=0, err=0.
- Misaligned word: addr=0x4001, mt_w, load → no bus_req, resp_valid with err=1 one cycle after accept. Same response for mt_x and for a store with mt_bu.
- Timeout: TIMEOUT_CYCLES=4, no ack → bus_req high for exactly 4 cycles, then resp err=1, rdata=0. With ack in the 4th cycle → err=0.
- Reset mid-BUS: assert rst=0 two cycles into a wait → bus_req=0 asynchronously, no resp_valid, req_ready=1 after release. A new access then completes normally.
